// File: rtl/game_clock_ctrl.sv
// game_clock_ctrl: run/pause/over sequencer with game-time, length, digit-scan and blink generation
module game_clock_ctrl #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned MAX_SECONDS = 5999,
  parameter int unsigned INIT_LENGTH = 3,
  parameter int unsigned MAX_LENGTH  = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        game_over,
  input  logic        grow,
  output logic [15:0] seconds,
  output logic [12:0] length,
  output logic        scan_en,
  output logic        display_blank,
  output logic [1:0]  state
);
  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(CLK_HZ / 2);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [15:0] seconds_q, seconds_d;
  logic [12:0] length_q, length_d;
  logic scan_en_q, scan_en_d, blank_q, blank_d;
  logic go, launch, counting, tick, grow_ok, scan_wrap, blinking, blink_wrap;
  always_comb begin
    go         = game_over && (state_q == RUN || state_q == PAUSE);
    launch     = start && (state_q == IDLE || state_q == OVER);
    state_d    = go ? OVER :
                 launch ? RUN :
                 (pause && state_q == RUN) ? PAUSE :
                 (pause && state_q == PAUSE) ? RUN : state_q;
    // the prescaler only advances on cycles that both start and stay in RUN
    counting   = state_q == RUN && state_d == RUN;
    tick       = counting && presc_q == PW'(CLK_HZ - 1);
    presc_d    = launch ? '0 : counting ? (tick ? '0 : presc_q + 1'b1) : presc_q;
    seconds_d  = launch ? 16'd0 :
                 (tick && seconds_q < 16'(MAX_SECONDS)) ? seconds_q + 16'd1 : seconds_q;
    grow_ok    = grow && state_q == RUN && !game_over;
    length_d   = launch ? 13'(INIT_LENGTH) :
                 (grow_ok && length_q < 13'(MAX_LENGTH)) ? length_q + 13'd1 : length_q;
    scan_wrap  = scan_q == SW'(SCAN_DIV - 1);
    scan_d     = scan_wrap ? '0 : scan_q + 1'b1;
    scan_en_d  = scan_wrap;
    blinking   = state_q == OVER && state_d == OVER;
    blink_wrap = blink_q == BW'(CLK_HZ / 2 - 1);
    blink_d    = (blinking && !blink_wrap) ? blink_q + 1'b1 : '0;
    blank_d    = blinking && (blink_wrap ? !blank_q : blank_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      scan_q    <= '0;
      blink_q   <= '0;
      seconds_q <= '0;
      length_q  <= 13'(INIT_LENGTH);
      scan_en_q <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      scan_q    <= scan_d;
      blink_q   <= blink_d;
      seconds_q <= seconds_d;
      length_q  <= length_d;
      scan_en_q <= scan_en_d;
      blank_q   <= blank_d;
    end
  end
  assign seconds       = seconds_q;
  assign length        = length_q;
  assign scan_en       = scan_en_q;
  assign display_blank = blank_q;
  assign state         = state_q;
endmodule

// File: tb/tb_game_clock_ctrl.sv
// tb_game_clock_ctrl: directed vectors against hand-computed expectations (CLK_HZ=10, SCAN_DIV=4)
module tb_game_clock_ctrl;
  logic clk, rst_n, start, pause, game_over, grow;
  logic [15:0] seconds;
  logic [12:0] length;
  logic scan_en, display_blank;
  logic [1:0] state;
  int n_vec = 0;
  int n_bad = 0;
  game_clock_ctrl #(
    .CLK_HZ(10), .SCAN_DIV(4), .MAX_SECONDS(5), .INIT_LENGTH(3), .MAX_LENGTH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .game_over(game_over),
    .grow(grow), .seconds(seconds), .length(length), .scan_en(scan_en),
    .display_blank(display_blank), .state(state)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    rst_n = 1'b1; start = 1'b0; pause = 1'b0; game_over = 1'b0; grow = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", state, 0);
    chk("rst_seconds", seconds, 0);
    chk("rst_length", length, 3);
    chk("rst_scan", scan_en, 0);
    chk("rst_blank", display_blank, 0);
    step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("idle_scan", scan_en, (k % 4 == 0) ? 1 : 0);
    end
    chk("idle_state", state, 0);
    chk("idle_seconds", seconds, 0);
    chk("idle_length", length, 3);
    chk("idle_blank", display_blank, 0);
    // test 2: start edge is cycle 1, seconds = (k-1)/10
    start = 1'b1; step(1); start = 1'b0;
    chk("start_state", state, 1);
    chk("start_seconds", seconds, 0);
    for (int k = 2; k <= 31; k++) begin
      step(1);
      chk("run_seconds", seconds, (k - 1) / 10);
    end
    // test 3: prescaler reads 6 after 6 more edges, pause holds it there
    step(6);
    pause = 1'b1; step(1); pause = 1'b0;
    chk("pause_state", state, 2);
    chk("pause_seconds", seconds, 3);
    step(50);
    chk("pause_hold_state", state, 2);
    chk("pause_hold_seconds", seconds, 3);
    pause = 1'b1; step(1); pause = 1'b0;
    chk("resume_state", state, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1);
      chk("resume_wait", seconds, 3);
    end
    step(1);
    chk("resume_tick", seconds, 4);
    // test 4: prescaler at 0; the 10th edge ticks, grow lands on it
    step(9);
    chk("pre_tick_seconds", seconds, 4);
    grow = 1'b1; step(1);
    chk("tick_grow_seconds", seconds, 5);
    chk("tick_grow_length", length, 4);
    step(1); chk("grow2", length, 5);
    step(1); chk("grow3", length, 6);
    step(1); chk("grow4_sat", length, 6);
    step(1); chk("grow5_sat", length, 6);
    grow = 1'b0;
    step(80);
    chk("sec_sat", seconds, 5);
    chk("sec_sat_state", state, 1);
    // test 5: game_over with grow
    game_over = 1'b1; grow = 1'b1; step(1); game_over = 1'b0; grow = 1'b0;
    chk("over_state", state, 3);
    chk("over_length", length, 6);
    chk("over_seconds", seconds, 5);
    chk("over_blank0", display_blank, 0);
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("blink", display_blank, (k / 5) % 2);
    end
    pause = 1'b1; step(1); pause = 1'b0;
    chk("over_pause_ign", state, 3);
    chk("over_frozen_sec", seconds, 5);
    start = 1'b1; step(1); start = 1'b0;
    chk("restart_state", state, 1);
    chk("restart_seconds", seconds, 0);
    chk("restart_length", length, 3);
    chk("restart_blank", display_blank, 0);
    game_over = 1'b1; grow = 1'b1; step(1); game_over = 1'b0; grow = 1'b0;
    chk("over2_state", state, 3);
    chk("over2_length", length, 3);
    start = 1'b1; game_over = 1'b1; step(1); start = 1'b0; game_over = 1'b0;
    chk("start_go_over", state, 1);
    // test 6: asynchronous reset between edges
    step(12);
    chk("pre_rst_seconds", seconds, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_seconds", seconds, 0);
    chk("arst_length", length, 3);
    chk("arst_scan", scan_en, 0);
    chk("arst_blank", display_blank, 0);
    #1 rst_n = 1'b1;
    step(1);
    pause = 1'b1; step(1); pause = 1'b0;
    chk("idle_pause_ign", state, 0);
    game_over = 1'b1; step(1); game_over = 1'b0;
    chk("idle_go_ign", state, 0);
    start = 1'b1; step(1); start = 1'b0;
    chk("start2_state", state, 1);
    pause = 1'b1; step(1); pause = 1'b0;
    chk("pause2_state", state, 2);
    start = 1'b1; step(1); start = 1'b0;
    chk("pause_start_ign", state, 2);
    grow = 1'b1; step(1); grow = 1'b0;
    chk("pause_grow_ign", length, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
